bsg_manycore_prof_ctrl: RTL

BSG_MANYCORE_PROF_CTRL -- requirements
Module: bsg_manycore_prof_ctrl

---
 rtl/bsg_manycore_prof_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bsg_manycore_prof_ctrl.sv
// Profiler run controller: IDLE/RUN/FINISH sequencing, gated event flags, and a saturating cycle counter.
// Optional auto-start after reset is enabled by defining BSG_MANYCORE_PROF_CTRL_AUTOSTART_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | profiler held in reset, waiting for start (or auto-start)
// S_RUN    | counting unfrozen cycles, forwarding events to the profiler
// S_FINISH | one-cycle finish pulse to the profiler, then back to IDLE
module bsg_manycore_prof_ctrl #(
    parameter logic [31:0] max_cycles_p = 32'hFFFF_FFFF,
    parameter int          num_ev_p     = 7
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                freeze_i,
    input  logic                cmd_v_i,
    input  logic [1:0]          cmd_i,
    output logic                cmd_ready_o,
    input  logic [num_ev_p-1:0] ev_i,
    output logic [num_ev_p-1:0] ev_o,
    output logic                reset_prof_o,
    output logic                finish_prof_o,
    output logic                running_o,
    output logic [31:0]         cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    localparam logic [1:0]  CmdStart  = 2'b01;
    localparam logic [1:0]  CmdStop   = 2'b10;
    localparam logic [1:0]  CmdClear  = 2'b11;
    localparam logic [31:0] LastCycle = max_cycles_p - 32'd1;

    state_e                state_q, state_d;
    logic [31:0]           cycles_q, cycles_d;
    logic [num_ev_p-1:0]   ev_q, ev_d;
    logic                  reset_prof_q, reset_prof_d;
    logic                  finish_q, finish_d;
    logic                  running_q, running_d;
    logic                  clr_pulse;
    logic                  ev_gate;

    logic cmd_acc, start_acc, stop_acc, clear_acc;
    logic auto_start, timeout, cnt_en;

    assign cmd_ready_o = (state_q != S_FINISH);
    assign cmd_acc     = cmd_v_i & cmd_ready_o;
    assign start_acc   = cmd_acc & (cmd_i == CmdStart);
    assign stop_acc    = cmd_acc & (cmd_i == CmdStop);
    assign clear_acc   = cmd_acc & (cmd_i == CmdClear);

    // Counter stops at the budget so it can never wrap, even if the budget is all ones.
    assign cnt_en  = ~freeze_i & (cycles_q != max_cycles_p);
    assign timeout = ~freeze_i & (cycles_q == LastCycle);

`ifdef BSG_MANYCORE_PROF_CTRL_AUTOSTART_EN
    logic auto_done_q, auto_done_d;

    // Armed once per reset; any entry into RUN (command or automatic) disarms it.
    assign auto_start  = ~auto_done_q & ~freeze_i;
    assign auto_done_d = auto_done_q | (state_d == S_RUN);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) auto_done_q <= 1'b0;
        else            auto_done_q <= auto_done_d;
    end
`else
    assign auto_start = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        clr_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                cycles_d = '0;
                if (start_acc | auto_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_en) cycles_d = cycles_q + 32'd1;
                // Timeout or stop ends the run; a clear in the same cycle loses.
                if (timeout | stop_acc) begin
                    state_d = S_FINISH;
                end else if (clear_acc) begin
                    cycles_d  = '0;
                    clr_pulse = 1'b1;
                end
            end
            S_FINISH: begin
                cycles_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                cycles_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Events only pass while staying in RUN unfrozen, so FINISH and the clear pulse see zeros.
    assign ev_gate      = (state_q == S_RUN) & ~freeze_i & (state_d == S_RUN) & ~clr_pulse;
    assign ev_d         = ev_i & {num_ev_p{ev_gate}};
    assign reset_prof_d = (state_d == S_IDLE) | clr_pulse;
    assign finish_d     = (state_d == S_FINISH);
    assign running_d    = (state_d == S_RUN);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            cycles_q     <= '0;
            ev_q         <= '0;
            reset_prof_q <= 1'b1;
            finish_q     <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            ev_q         <= ev_d;
            reset_prof_q <= reset_prof_d;
            finish_q     <= finish_d;
            running_q    <= running_d;
        end
    end

    assign ev_o          = ev_q;
    assign reset_prof_o  = reset_prof_q;
    assign finish_prof_o = finish_q;
    assign running_o     = running_q;
    assign cycles_o      = cycles_q;

endmodule
